// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// fields, ALU select codes and the ALUOp shorthand used between FSM and decoder.
package ctrl_pkg;

  localparam int ALU_SEL_W = 4;
  localparam int STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Per-state control word before reset gating; alu_use marks states that drive the ALU.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       alu_use;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational ALU control: maps {ALUOp, funct} to the 4-bit ALU select and
// flags funct codes it does not recognise.
module alu_sel_decode
  import ctrl_pkg::*;
(
  input  logic [1:0]           alu_op,
  input  logic [5:0]           funct,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 bad_funct
);

  always_comb begin
    alu_sel   = ALU_ADD;
    bad_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_sel = ALU_ADD;
      ALUOP_SUB: alu_sel = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: begin
            alu_sel   = ALU_ADD;
            bad_funct = 1'b1;
          end
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 32-bit datapath: sequences fetch/decode/execute
// for R-type, lw, sw, beq, addi and j, and drives every datapath enable.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zf,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [SEL_W-1:0] alu_sel,
  output logic             illegal,
  output logic [ST_W-1:0]  state_o
);

  state_t                 state;
  state_t                 next_state;
  ctrl_t                  ctrl;
  ctrl_t                  ctrl_g;
  logic                   op_illegal;
  logic [ALU_SEL_W-1:0]   dec_sel;
  logic                   bad_funct;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    ctrl       = '0;
    next_state = S_FETCH;
    op_illegal = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        next_state     = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      op_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        if (opcode == OP_SW)      next_state = S_MEMWR;
        else if (opcode == OP_LW) next_state = S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        next_state    = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        next_state     = S_RTWB;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_use   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        next_state     = S_ADDIWB;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  alu_sel_decode u_alu_sel_decode (
    .alu_op    (ctrl.alu_op),
    .funct     (funct),
    .alu_sel   (dec_sel),
    .bad_funct (bad_funct)
  );

  // Reset forces every output low in the same cycle, independent of the current state.
  assign ctrl_g     = rst ? '0 : ctrl;
  assign pc_en      = ctrl_g.pc_write | (ctrl_g.branch & zf);
  assign iord       = ctrl_g.iord;
  assign mem_read   = ctrl_g.mem_read;
  assign mem_write  = ctrl_g.mem_write;
  assign ir_write   = ctrl_g.ir_write;
  assign reg_dst    = ctrl_g.reg_dst;
  assign mem_to_reg = ctrl_g.mem_to_reg;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign pc_src     = ctrl_g.pc_src;
  assign alu_sel    = ctrl_g.alu_use ? SEL_W'(dec_sel) : '0;
  assign illegal    = !rst && (op_illegal || (state == S_EXECUTE && bad_funct));
  assign state_o    = rst ? '0 : ST_W'(state);

endmodule
